// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encoding,
// register index width and the load-use detection helper.
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam int WAIT_W = 16;

  // $zero is never a real dependence, and rt only matters when ID actually reads it
  function automatic logic detectLoadUse(
    input logic             memRead,
    input logic [REG_W-1:0] exRt,
    input logic [REG_W-1:0] idRs,
    input logic [REG_W-1:0] idRt,
    input logic             usesRt
  );
    logic hit;
    hit = (exRt == idRs) || (usesRt && (exRt == idRt));
    return memRead && (exRt != ZERO_REG) && hit;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Hazard controller bundle: pipeline-side hazard inputs plus the stall/flush
// controls and debug counters returned to the pipeline.
interface hazard_stall_unit_if #(parameter int CNT_W = 16);
  import hazard_stall_unit_pkg::*;

  logic             Id_Ex_MemRead;
  logic [REG_W-1:0] Id_Ex_rt;
  logic [REG_W-1:0] If_Id_rs;
  logic [REG_W-1:0] If_Id_rt;
  logic             If_Id_UsesRt;
  logic             Branch_taken;
  logic             Ex_Mem_MemAccess;
  logic             Dmem_ready;

  logic             PC_Write;
  logic             If_Id_Write;
  logic             Id_Ex_Write;
  logic             Ex_Mem_Write;
  logic             Id_Ex_Bubble;
  logic             If_Id_Flush;
  logic             Id_Ex_Flush;
  logic             Mem_Timeout;
  logic [CNT_W-1:0] Stall_cnt;
  logic [CNT_W-1:0] Flush_cnt;

  modport master (
    output Id_Ex_MemRead, Id_Ex_rt, If_Id_rs, If_Id_rt, If_Id_UsesRt,
           Branch_taken, Ex_Mem_MemAccess, Dmem_ready,
    input  PC_Write, If_Id_Write, Id_Ex_Write, Ex_Mem_Write, Id_Ex_Bubble,
           If_Id_Flush, Id_Ex_Flush, Mem_Timeout, Stall_cnt, Flush_cnt
  );

  modport slave (
    input  Id_Ex_MemRead, Id_Ex_rt, If_Id_rs, If_Id_rt, If_Id_UsesRt,
           Branch_taken, Ex_Mem_MemAccess, Dmem_ready,
    output PC_Write, If_Id_Write, Id_Ex_Write, Ex_Mem_Write, Id_Ex_Bubble,
           If_Id_Flush, Id_Ex_Flush, Mem_Timeout, Stall_cnt, Flush_cnt
  );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory freezes, with saturating debug counters and a sticky timeout.
module hazard_stall_unit #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  hazard_stall_unit_if.slave hz
);
  import hazard_stall_unit_pkg::*;

  localparam logic [WAIT_W-1:0] TIMEOUT_AT = WAIT_W'(WAIT_MAX - 1);

  logic [0:0]        state;
  logic [0:0]        stateNext;
  logic              freeze;
  logic              loadUse;
  logic              branchFlush;
  logic              loadStall;
  logic [WAIT_W-1:0] waitCnt;
  logic              memTimeout;

  assign loadUse = detectLoadUse(hz.Id_Ex_MemRead, hz.Id_Ex_rt, hz.If_Id_rs,
                                 hz.If_Id_rt, hz.If_Id_UsesRt);

  always_comb begin
    freeze = 1'b0;
    if (state == RUN) begin
      freeze = hz.Ex_Mem_MemAccess && !hz.Dmem_ready;
    end else begin
      freeze = !hz.Dmem_ready;
    end
  end

  assign branchFlush = !freeze && hz.Branch_taken;
  assign loadStall   = !freeze && !hz.Branch_taken && loadUse;

  // Outputs are forced to their idle values while reset is held, so the
  // pipeline sees a clean run state regardless of what the inputs are doing.
  always_comb begin
    hz.PC_Write     = 1'b1;
    hz.If_Id_Write  = 1'b1;
    hz.Id_Ex_Write  = 1'b1;
    hz.Ex_Mem_Write = 1'b1;
    hz.Id_Ex_Bubble = 1'b0;
    hz.If_Id_Flush  = 1'b0;
    hz.Id_Ex_Flush  = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        hz.PC_Write     = 1'b0;
        hz.If_Id_Write  = 1'b0;
        hz.Id_Ex_Write  = 1'b0;
        hz.Ex_Mem_Write = 1'b0;
      end else if (hz.Branch_taken) begin
        hz.If_Id_Flush  = 1'b1;
        hz.Id_Ex_Flush  = 1'b1;
      end else if (loadUse) begin
        hz.PC_Write     = 1'b0;
        hz.If_Id_Write  = 1'b0;
        hz.Id_Ex_Bubble = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    if (state == RUN) begin
      if (hz.Ex_Mem_MemAccess && !hz.Dmem_ready) begin
        stateNext = MEM_WAIT;
      end
    end else if (hz.Dmem_ready) begin
      stateNext = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // The wait counter is cleared on every unfrozen cycle, so each new freeze
  // starts counting from zero even if it follows a release back-to-back.
  sat_counter #(.W(WAIT_W)) waitCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze),
    .clr   (!freeze),
    .count (waitCnt)
  );

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (freeze || loadStall),
    .clr   (1'b0),
    .count (hz.Stall_cnt)
  );

  sat_counter #(.W(CNT_W)) flushCounter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (branchFlush),
    .clr   (1'b0),
    .count (hz.Flush_cnt)
  );

  // Sets on the edge that closes the WAIT_MAX-th frozen cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memTimeout <= 1'b0;
    end else if (freeze && (waitCnt >= TIMEOUT_AT)) begin
      memTimeout <= 1'b1;
    end
  end

  assign hz.Mem_Timeout = memTimeout;

endmodule
